// File: rtl/uart_rx_pkt_ctrl.sv
// Frames UART receiver bytes into SYNC/LEN/payload/CSUM packets and strobes the receiver clock enable.
// Latency: each response is registered one cycle after its RX_VLD; no backpressure, the consumer takes every byte.
module uart_rx_pkt_ctrl #(
    parameter int unsigned CLK_DIV     = 2,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter int unsigned MAX_LEN     = 64,
    parameter int unsigned TIMEOUT_CYC = 4096
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       ENABLE,
    output logic       UART_CLK_EN,
    input  logic [7:0] RX_DATA,
    input  logic       RX_VLD,
    input  logic       RX_FRAME_ERROR,
    output logic [7:0] PLD_DATA,
    output logic       PLD_VLD,
    output logic       PLD_FIRST,
    output logic       PLD_LAST,
    output logic       PKT_DONE,
    output logic       PKT_ERR,
    output logic [1:0] ERR_CODE,
    output logic [7:0] ERR_CNT,
    output logic       BUSY
);
    localparam int unsigned     DW        = $clog2(CLK_DIV);
    localparam int unsigned     TW        = $clog2(TIMEOUT_CYC);
    localparam logic [DW-1:0]   DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT_CYC - 2);
    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);

    localparam logic [1:0] ERR_CSUM    = 2'd0;
    localparam logic [1:0] ERR_FRAME   = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    typedef enum logic [1:0] {ST_IDLE, ST_LEN, ST_PAYLOAD, ST_CSUM} state_t;

    state_t        r_state, w_state_nxt;
    logic [7:0]    r_len, r_rem, r_sum;
    logic [7:0]    w_len_nxt, w_rem_nxt, w_sum_nxt;
    logic [TW-1:0] r_to_cnt, w_to_nxt;
    logic [DW-1:0] r_div_cnt;
    logic          r_uart_clk_en;
    logic [7:0]    r_pld_data, w_pld_data;
    logic          r_pld_vld, r_pld_first, r_pld_last, r_pkt_done, r_pkt_err;
    logic          w_pld_vld, w_pld_first, w_pld_last, w_pkt_done, w_pkt_err;
    logic [1:0]    r_err_code, w_err_code;
    logic [7:0]    r_err_cnt;
    logic          w_timeout;

    // Strobe is registered, so the first pulse lands CLK_DIV cycles after ENABLE rises.
    always_ff @(posedge CLK) begin
        if (!RST || !ENABLE) begin
            r_div_cnt     <= '0;
            r_uart_clk_en <= 1'b0;
        end else begin
            r_uart_clk_en <= (r_div_cnt == DIV_LAST);
            r_div_cnt     <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + 1'b1;
        end
    end

    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign w_timeout = (r_state != ST_IDLE) && !RX_VLD && (r_to_cnt == TO_LAST);

    always_comb begin
        w_state_nxt = r_state;
        w_len_nxt   = r_len;
        w_rem_nxt   = r_rem;
        w_sum_nxt   = r_sum;
        w_pld_data  = r_pld_data;
        w_pld_vld   = 1'b0;
        w_pld_first = 1'b0;
        w_pld_last  = 1'b0;
        w_pkt_done  = 1'b0;
        w_pkt_err   = 1'b0;
        w_err_code  = r_err_code;
        if (!ENABLE) begin
            w_state_nxt = ST_IDLE;
        end else if (RX_VLD) begin
            if (r_state != ST_IDLE && RX_FRAME_ERROR) begin
                w_pkt_err   = 1'b1;
                w_err_code  = ERR_FRAME;
                w_state_nxt = ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (!RX_FRAME_ERROR && RX_DATA == SYNC_BYTE) w_state_nxt = ST_LEN;
                    end
                    ST_LEN: begin
                        w_len_nxt = RX_DATA;
                        w_rem_nxt = RX_DATA;
                        w_sum_nxt = RX_DATA;
                        if (RX_DATA == 8'd0) begin
                            w_state_nxt = ST_CSUM;
                        end else if (RX_DATA > MAX_LEN_B) begin
                            w_pkt_err   = 1'b1;
                            w_err_code  = ERR_LEN;
                            w_state_nxt = ST_IDLE;
                        end else begin
                            w_state_nxt = ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        w_pld_data  = RX_DATA;
                        w_pld_vld   = 1'b1;
                        w_pld_first = (r_rem == r_len);
                        w_pld_last  = (r_rem == 8'd1);
                        w_sum_nxt   = r_sum + RX_DATA;
                        w_rem_nxt   = r_rem - 8'd1;
                        if (r_rem == 8'd1) w_state_nxt = ST_CSUM;
                    end
                    ST_CSUM: begin
                        if (RX_DATA == r_sum) begin
                            w_pkt_done = 1'b1;
                        end else begin
                            w_pkt_err  = 1'b1;
                            w_err_code = ERR_CSUM;
                        end
                        w_state_nxt = ST_IDLE;
                    end
                    default: w_state_nxt = ST_IDLE;
                endcase
            end
        end else if (w_timeout) begin
            w_pkt_err   = 1'b1;
            w_err_code  = ERR_TIMEOUT;
            w_state_nxt = ST_IDLE;
        end
        w_to_nxt = (w_state_nxt == ST_IDLE || RX_VLD) ? '0 : r_to_cnt + 1'b1;
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state     <= ST_IDLE;
            r_len       <= '0;
            r_rem       <= '0;
            r_sum       <= '0;
            r_to_cnt    <= '0;
            r_pld_data  <= '0;
            r_pld_vld   <= 1'b0;
            r_pld_first <= 1'b0;
            r_pld_last  <= 1'b0;
            r_pkt_done  <= 1'b0;
            r_pkt_err   <= 1'b0;
            r_err_code  <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_len       <= w_len_nxt;
            r_rem       <= w_rem_nxt;
            r_sum       <= w_sum_nxt;
            r_to_cnt    <= w_to_nxt;
            r_pld_data  <= w_pld_data;
            r_pld_vld   <= w_pld_vld;
            r_pld_first <= w_pld_first;
            r_pld_last  <= w_pld_last;
            r_pkt_done  <= w_pkt_done;
            r_pkt_err   <= w_pkt_err;
            r_err_code  <= w_err_code;
            if (w_pkt_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign UART_CLK_EN = r_uart_clk_en;
    assign PLD_DATA    = r_pld_data;
    assign PLD_VLD     = r_pld_vld;
    assign PLD_FIRST   = r_pld_first;
    assign PLD_LAST    = r_pld_last;
    assign PKT_DONE    = r_pkt_done;
    assign PKT_ERR     = r_pkt_err;
    assign ERR_CODE    = r_err_code;
    assign ERR_CNT     = r_err_cnt;
    assign BUSY        = (r_state != ST_IDLE);
endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Scoreboarded bench: packet-level stimulus pushes expected events, a negedge monitor pops and compares them.
module tb_uart_rx_pkt_ctrl;
    localparam int         CLK_DIV     = 2;
    localparam logic [7:0] SYNC        = 8'hA5;
    localparam int         MAX_LEN     = 64;
    localparam int         TIMEOUT_CYC = 4096;
    localparam int         K_PLD = 1, K_DONE = 2, K_ERR = 3;

    logic       CLK = 1'b0;
    logic       RST, ENABLE, UART_CLK_EN;
    logic [7:0] RX_DATA;
    logic       RX_VLD, RX_FRAME_ERROR;
    logic [7:0] PLD_DATA;
    logic       PLD_VLD, PLD_FIRST, PLD_LAST, PKT_DONE, PKT_ERR;
    logic [1:0] ERR_CODE;
    logic [7:0] ERR_CNT;
    logic       BUSY;

    typedef struct {
        int         kind;
        logic [7:0] dat;
        bit         first;
        bit         last;
        logic [1:0] code;
        logic [7:0] cnt;
        int         cyc;
    } exp_t;

    exp_t       exp_q[$];
    exp_t       m_e;
    int         mon_kind;
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         last_drv_cyc = 0;
    int         gap_max = 2;
    int         model_cnt = 0;
    logic [1:0] model_code = 2'd0;

    uart_rx_pkt_ctrl #(
        .CLK_DIV(CLK_DIV), .SYNC_BYTE(SYNC), .MAX_LEN(MAX_LEN), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .UART_CLK_EN(UART_CLK_EN),
        .RX_DATA(RX_DATA), .RX_VLD(RX_VLD), .RX_FRAME_ERROR(RX_FRAME_ERROR),
        .PLD_DATA(PLD_DATA), .PLD_VLD(PLD_VLD), .PLD_FIRST(PLD_FIRST), .PLD_LAST(PLD_LAST),
        .PKT_DONE(PKT_DONE), .PKT_ERR(PKT_ERR), .ERR_CODE(ERR_CODE), .ERR_CNT(ERR_CNT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input logic [7:0] d, input bit f, input bit l,
                        input logic [1:0] code, input int at);
        exp_t e;
        if (kind == K_ERR) begin
            model_code = code;
            if (model_cnt < 255) model_cnt++;
        end
        e.kind = kind; e.dat = d; e.first = f; e.last = l;
        e.code = model_code; e.cnt = 8'(model_cnt); e.cyc = at;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 with RX_VLD already dropped.
    task automatic send_byte(input logic [7:0] d, input bit fe, input int kind, input bit f,
                             input bit l, input logic [1:0] code);
        repeat ($urandom_range(0, gap_max)) begin @(posedge CLK); #1; end
        RX_DATA = d; RX_VLD = 1'b1; RX_FRAME_ERROR = fe;
        last_drv_cyc = cyc;
        if (kind != 0) push(kind, d, f, l, code, cyc + 1);
        @(posedge CLK); #1;
        RX_VLD = 1'b0; RX_FRAME_ERROR = 1'($urandom); RX_DATA = 8'($urandom);
    endtask

    task automatic tx(input logic [7:0] d);                 send_byte(d, 1'b0, 0, 1'b0, 1'b0, 2'd0); endtask
    task automatic tx_pld(input logic [7:0] d, input bit f, input bit l); send_byte(d, 1'b0, K_PLD, f, l, 2'd0); endtask
    task automatic tx_done(input logic [7:0] d);            send_byte(d, 1'b0, K_DONE, 1'b0, 1'b0, 2'd0); endtask
    task automatic tx_err(input logic [7:0] d, input bit fe, input logic [1:0] code);
        send_byte(d, fe, K_ERR, 1'b0, 1'b0, code);
    endtask

    task automatic drain();
        repeat (4) begin @(posedge CLK); #1; end
    endtask

    // Silence after the last byte: the error must appear TIMEOUT_CYC cycles after that byte was sampled.
    task automatic wait_timeout();
        push(K_ERR, 8'd0, 1'b0, 1'b0, 2'd3, last_drv_cyc + TIMEOUT_CYC);
        repeat (TIMEOUT_CYC + 2) begin @(posedge CLK); #1; end
        chk("busy_after_timeout", int'(BUSY), 0);
    endtask

    task automatic rand_pkt();
        int kind, len, p;
        logic [7:0] d, sum;
        repeat ($urandom_range(0, 2)) begin
            d = 8'($urandom);
            send_byte(d, (d == SYNC) ? 1'b1 : 1'($urandom), 0, 1'b0, 1'b0, 2'd0);
        end
        kind = $urandom_range(0, 3);
        tx(SYNC);
        case (kind)
            0, 1: begin
                len = ($urandom_range(0, 9) == 0) ? MAX_LEN : $urandom_range(0, 12);
                sum = 8'(len);
                tx(8'(len));
                for (int i = 0; i < len; i++) begin
                    d = 8'($urandom);
                    sum = sum + d;
                    tx_pld(d, i == 0, i == len - 1);
                end
                if (kind == 0) tx_done(sum);
                else tx_err(sum + 8'($urandom_range(1, 255)), 1'b0, 2'd0);
            end
            2: tx_err(8'($urandom_range(MAX_LEN + 1, 255)), 1'b0, 2'd2);
            default: begin
                len = $urandom_range(1, 8);
                p = $urandom_range(0, len + 1);
                if (p == 0) begin
                    tx_err(8'(len), 1'b1, 2'd1);
                end else begin
                    tx(8'(len));
                    for (int i = 0; i < p - 1; i++) tx_pld(8'($urandom), i == 0, i == len - 1);
                    tx_err(8'($urandom), 1'b1, 2'd1);
                end
            end
        endcase
    endtask

    always @(negedge CLK) begin
        if (PLD_VLD || PKT_DONE || PKT_ERR) begin
            chk("single_event_per_cycle", int'(PLD_VLD) + int'(PKT_DONE) + int'(PKT_ERR), 1);
            mon_kind = PLD_VLD ? K_PLD : (PKT_DONE ? K_DONE : K_ERR);
            if (exp_q.size() == 0) begin
                chk("unexpected_event_kind", mon_kind, 0);
            end else begin
                m_e = exp_q.pop_front();
                chk("event_kind", mon_kind, m_e.kind);
                chk("event_cycle", cyc, m_e.cyc);
                if (m_e.kind == K_PLD) begin
                    chk("pld_data", int'(PLD_DATA), int'(m_e.dat));
                    chk("pld_first", int'(PLD_FIRST), int'(m_e.first));
                    chk("pld_last", int'(PLD_LAST), int'(m_e.last));
                end else begin
                    chk("err_code", int'(ERR_CODE), int'(m_e.code));
                    chk("err_cnt", int'(ERR_CNT), int'(m_e.cnt));
                end
            end
        end
    end

    initial begin
        RST = 1'b0; ENABLE = 1'b1; RX_DATA = 8'd0; RX_VLD = 1'b0; RX_FRAME_ERROR = 1'b0;
        repeat (3) begin @(posedge CLK); #1; end
        chk("rst_uart_clk_en", int'(UART_CLK_EN), 0);
        chk("rst_pld_vld", int'(PLD_VLD), 0);
        chk("rst_pld_data", int'(PLD_DATA), 0);
        chk("rst_pkt_done", int'(PKT_DONE), 0);
        chk("rst_pkt_err", int'(PKT_ERR), 0);
        chk("rst_err_code", int'(ERR_CODE), 0);
        chk("rst_err_cnt", int'(ERR_CNT), 0);
        chk("rst_busy", int'(BUSY), 0);
        RST = 1'b1;
        for (int j = 1; j <= 6; j++) begin
            @(posedge CLK); #1;
            chk("div_after_reset", int'(UART_CLK_EN), int'(j % CLK_DIV == 0));
        end

        tx(SYNC); tx(8'h03); tx_pld(8'h10, 1'b1, 1'b0); tx_pld(8'h20, 1'b0, 1'b0);
        tx_pld(8'h30, 1'b0, 1'b1); tx_done(8'h63);
        drain();
        chk("good_pkt_err_cnt", int'(ERR_CNT), 0);

        tx(SYNC); tx(8'h02); tx_pld(8'h01, 1'b1, 1'b0); tx_pld(8'h02, 1'b0, 1'b1); tx_err(8'h00, 1'b0, 2'd0);
        drain();
        chk("bad_csum_err_cnt", int'(ERR_CNT), 1);
        tx(SYNC); tx(8'h00); tx_done(8'h00);
        tx(SYNC); tx_err(8'h41, 1'b0, 2'd2);
        drain();
        chk("bad_len_code", int'(ERR_CODE), 2);
        tx(SYNC); tx(8'h02); tx_pld(8'h11, 1'b1, 1'b0); tx_err(8'h22, 1'b1, 2'd1);
        drain();
        chk("frame_err_code", int'(ERR_CODE), 1);

        tx(SYNC); tx(8'h04);
        chk("busy_in_pkt", int'(BUSY), 1);
        tx_pld(8'h01, 1'b1, 1'b0);
        wait_timeout();
        chk("timeout_code", int'(ERR_CODE), 3);

        // A byte landing in the would-be expiry cycle is processed instead of timing out.
        tx(SYNC); tx(8'h03); tx_pld(8'h5A, 1'b1, 1'b0);
        repeat (TIMEOUT_CYC - 2) begin @(posedge CLK); #1; end
        gap_max = 0;
        tx_pld(8'hA5, 1'b0, 1'b0);
        gap_max = 2;
        tx_pld(8'h01, 1'b0, 1'b1);
        tx_done(8'(8'h03 + 8'h5A + 8'hA5 + 8'h01));

        tx(SYNC); tx(8'h03); tx_pld(8'h10, 1'b1, 1'b0);
        ENABLE = 1'b0;
        @(posedge CLK); #1;
        chk("enable_low_busy", int'(BUSY), 0);
        chk("enable_low_clk_en", int'(UART_CLK_EN), 0);
        repeat (2) begin @(posedge CLK); #1; end
        chk("enable_low_clk_en_held", int'(UART_CLK_EN), 0);
        ENABLE = 1'b1;
        for (int j = 1; j <= 4; j++) begin
            @(posedge CLK); #1;
            chk("div_restart", int'(UART_CLK_EN), int'(j % CLK_DIV == 0));
        end
        chk("enable_low_err_cnt", int'(ERR_CNT), model_cnt);

        repeat (150) rand_pkt();
        drain();

        for (int t = 0; t < 2; t++) begin
            int len, m;
            len = $urandom_range(2, 8);
            m = (t == 0) ? 0 : $urandom_range(1, len - 1);
            tx(SYNC); tx(8'(len));
            for (int i = 0; i < m; i++) tx_pld(8'($urandom), i == 0, 1'b0);
            wait_timeout();
        end

        tx(SYNC); tx(8'h02); tx_pld(8'h11, 1'b1, 1'b0);
        RST = 1'b0;
        @(posedge CLK); #1;
        chk("rst_mid_busy", int'(BUSY), 0);
        chk("rst_mid_pkt_err", int'(PKT_ERR), 0);
        chk("rst_mid_err_cnt", int'(ERR_CNT), 0);
        chk("rst_mid_err_code", int'(ERR_CODE), 0);
        RST = 1'b1;
        model_cnt = 0; model_code = 2'd0;
        drain();

        repeat (300) begin
            logic [7:0] d;
            d = 8'($urandom);
            tx(SYNC); tx(8'h01); tx_pld(d, 1'b1, 1'b1);
            tx_err(8'h01 + d + 8'($urandom_range(1, 255)), 1'b0, 2'd0);
        end
        drain();
        chk("err_cnt_saturated", int'(ERR_CNT), 255);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1500000;
        failures++;
        $display("FAIL watchdog: run did not complete, cyc=%0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end
endmodule
